// File: rtl/mux_16by1_pkg.sv
// Package: mux_16by1_pkg
//
// Shared constants for the registered 16:1 lane selector and its bench.
// The selector is built as a two-level tree of 4:1 leaves, so the leaf
// geometry is kept here alongside the top-level lane count.
//
// Contents:
//   N_LANES     number of input lanes on the top-level selector
//   SEL_W       width of the top-level lane index
//   LEAF_LANES  lanes handled by one leaf selector
//   LEAF_SEL_W  index width of one leaf selector
package mux_16by1_pkg;

    localparam int N_LANES    = 16;
    localparam int SEL_W      = 4;
    localparam int LEAF_LANES = 4;
    localparam int LEAF_SEL_W = 2;

endpackage

// File: rtl/mux_16by1_4by1.sv
// Module: mux_4by1
//
// Purely combinational 4:1 lane selector, the leaf of the 16:1 tree.
//
// Parameters:
//   WIDTH  bits per lane
//
// Ports:
//   in   [4*WIDTH]  four packed lanes, lane 0 at the LSBs
//   sel  [2]        lane index 0..3
//   out  [WIDTH]    selected lane
module mux_4by1
    import mux_16by1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [LEAF_LANES*WIDTH-1:0] in,
    input  logic [LEAF_SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]            out
);

    // Explicit case decode so an unknown select code falls to the default
    // branch instead of producing a partially indexed slice.
    always_comb begin
        out = '0;
        case (sel)
            2'd0:    out = in[0*WIDTH +: WIDTH];
            2'd1:    out = in[1*WIDTH +: WIDTH];
            2'd2:    out = in[2*WIDTH +: WIDTH];
            2'd3:    out = in[3*WIDTH +: WIDTH];
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/mux_16by1.sv
// Module: mux_16by1
//
// Registered 16-to-1 lane selector. One of sixteen WIDTH-bit lanes packed on
// `in` is picked by `sel` and presented on `out` one clock later.
//
// Parameters:
//   WIDTH  bits per lane
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         [16*WIDTH] packed lanes, lane k at in[k*WIDTH +: WIDTH]
//   sel        [4] lane index 0..15
//   in_valid   qualifies in/sel this cycle
//   out        [WIDTH] registered selected lane (holds when in_valid is low)
//   out_valid  out was captured from a valid input on the last edge
module mux_16by1
    import mux_16by1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_LANES*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid
);

    localparam int GROUP_W = LEAF_LANES * WIDTH;

    // Level-1 outputs: one lane per group of four, packed group 0 at LSBs.
    logic [GROUP_W-1:0] level1;
    logic [WIDTH-1:0]   picked;

    // First level: each leaf picks within its group of four lanes using the
    // low index bits.
    for (genvar g = 0; g < LEAF_LANES; g++) begin : g_level1
        mux_4by1 #(
            .WIDTH (WIDTH)
        ) u_leaf (
            .in  (in[g*GROUP_W +: GROUP_W]),
            .sel (sel[LEAF_SEL_W-1:0]),
            .out (level1[g*WIDTH +: WIDTH])
        );
    end

    // Second level: the high index bits choose which group's pick survives.
    mux_4by1 #(
        .WIDTH (WIDTH)
    ) u_final (
        .in  (level1),
        .sel (sel[SEL_W-1:LEAF_SEL_W]),
        .out (picked)
    );

    // Output register: data only moves on a valid input so the last result
    // is held across idle cycles, while the valid flag simply tracks whether
    // the most recent edge saw a valid input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= picked;
            end
        end
    end

endmodule

// File: tb/tb_mux_16by1.sv
// Testbench: tb_mux_16by1
//
// Drives two selector instances (WIDTH=1 and WIDTH=8) from a shared clock
// and reset. Expected values come from a lane-shift reference model and the
// directed values listed for each scenario.
module tb_mux_16by1;
    import mux_16by1_pkg::*;

    logic                clk;
    logic                rst_n;

    logic [15:0]         in_w1;
    logic [SEL_W-1:0]    sel_w1;
    logic                valid_w1;
    logic [0:0]          out_w1;
    logic                out_valid_w1;

    logic [127:0]        in_w8;
    logic [SEL_W-1:0]    sel_w8;
    logic                valid_w8;
    logic [7:0]          out_w8;
    logic                out_valid_w8;

    int errors = 0;
    int checks = 0;

    mux_16by1 #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_w1),
        .sel       (sel_w1),
        .in_valid  (valid_w1),
        .out       (out_w1),
        .out_valid (out_valid_w1)
    );

    mux_16by1 #(.WIDTH(8)) dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_w8),
        .sel       (sel_w8),
        .in_valid  (valid_w8),
        .out       (out_w8),
        .out_valid (out_valid_w8)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a lane is the packed vector shifted down by
    // lane*WIDTH and truncated to WIDTH bits.
    function automatic logic [0:0] ref_pick1(input logic [15:0] v, input int s);
        return 1'((v >> s) & 16'h1);
    endfunction

    function automatic logic [7:0] ref_pick8(input logic [127:0] v, input int s);
        return 8'(v >> (s * 8));
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_w1    = 16'hFFFF;
        sel_w1   = 4'd5;
        valid_w1 = 1'b1;
        in_w8    = '1;
        sel_w8   = 4'd5;
        valid_w8 = 1'b1;
        #1;
        checks++;
        if (out_w1 !== 1'b0 || out_valid_w1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_immediate_w1: out=%b valid=%b, want out=0 valid=0",
                     out_w1, out_valid_w1);
        end
        repeat (3) applyStimulus();
        checks++;
        if (out_w1 !== 1'b0 || out_valid_w1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_clocked_w1: out=%b valid=%b, want out=0 valid=0",
                     out_w1, out_valid_w1);
        end
        checks++;
        if (out_w8 !== 8'h00 || out_valid_w8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_clocked_w8: out=%h valid=%b, want out=00 valid=0",
                     out_w8, out_valid_w8);
        end
        // Release away from the edge; the next edge is the first capture.
        rst_n    = 1'b1;
        valid_w8 = 1'b0;
        in_w1    = 16'h0020;
        sel_w1   = 4'd5;
        applyStimulus();
        checks++;
        if (out_w1 !== 1'b1 || out_valid_w1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_capture: out=%b valid=%b, want out=1 valid=1",
                     out_w1, out_valid_w1);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] expected_seq;
        expected_seq = 16'b1100110011001100;
        in_w1    = 16'b1100110011001100;
        valid_w1 = 1'b1;
        for (int s = 0; s < N_LANES; s++) begin
            sel_w1 = 4'(s);
            applyStimulus();
            checks++;
            if (out_w1 !== expected_seq[s] || out_valid_w1 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sweep sel=%0d: out=%b valid=%b, want out=%b valid=1",
                         s, out_w1, out_valid_w1, expected_seq[s]);
            end
        end
    endtask

    task automatic test_walking_one();
        valid_w1 = 1'b1;
        for (int k = 0; k < N_LANES; k++) begin
            in_w1  = 16'(1) << k;
            sel_w1 = 4'(k);
            applyStimulus();
            checks++;
            if (out_w1 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL walk_hit k=%0d: out=%b, want 1", k, out_w1);
            end
            sel_w1 = 4'((k + 1) % N_LANES);
            applyStimulus();
            checks++;
            if (out_w1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL walk_miss k=%0d: out=%b, want 0", k, out_w1);
            end
        end
    endtask

    task automatic test_hold();
        in_w1    = 16'hCCCC;
        sel_w1   = 4'd2;
        valid_w1 = 1'b1;
        applyStimulus();
        checks++;
        if (out_w1 !== 1'b1 || out_valid_w1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_capture: out=%b valid=%b, want out=1 valid=1",
                     out_w1, out_valid_w1);
        end
        in_w1    = 16'h0000;
        valid_w1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checks++;
            if (out_w1 !== 1'b1 || out_valid_w1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: out=%b valid=%b, want out=1 valid=0",
                         c, out_w1, out_valid_w1);
            end
        end
    endtask

    task automatic test_async_reset();
        in_w1    = 16'hFFFF;
        sel_w1   = 4'd7;
        valid_w1 = 1'b1;
        applyStimulus();
        checks++;
        if (out_w1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_precondition: out=%b, want 1", out_w1);
        end
        // Assert reset mid-cycle with a capture pending; no edge occurs here.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_w1 !== 1'b0 || out_valid_w1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_clear: out=%b valid=%b, want out=0 valid=0",
                     out_w1, out_valid_w1);
        end
        applyStimulus();
        checks++;
        if (out_w1 !== 1'b0 || out_valid_w1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_held: out=%b valid=%b, want out=0 valid=0",
                     out_w1, out_valid_w1);
        end
        rst_n  = 1'b1;
        in_w1  = 16'hCCCC;
        sel_w1 = 4'd3;
        applyStimulus();
        checks++;
        if (out_w1 !== 1'b1 || out_valid_w1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_release_capture: out=%b valid=%b, want out=1 valid=1",
                     out_w1, out_valid_w1);
        end
    endtask

    task automatic test_width8();
        logic [3:0] sels [3];
        logic [7:0] wants [3];
        sels  = '{4'd15, 4'd0, 4'd9};
        wants = '{8'hFF, 8'h00, 8'h99};
        for (int k = 0; k < N_LANES; k++) begin
            in_w8[k*8 +: 8] = 8'(k * 17);
        end
        valid_w8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_w8 = sels[i];
            applyStimulus();
            checks++;
            if (out_w8 !== wants[i] || out_valid_w8 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL width8 sel=%0d: out=%h valid=%b, want out=%h valid=1",
                         sels[i], out_w8, out_valid_w8, wants[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [0:0] exp_w1;
        logic       expv_w1;
        logic [7:0] exp_w8;
        logic       expv_w8;
        exp_w1  = '0;
        expv_w1 = 1'b0;
        exp_w8  = '0;
        expv_w8 = 1'b0;
        for (int n = 0; n < 150; n++) begin
            in_w1  = 16'($urandom);
            sel_w1 = 4'($urandom_range(0, 15));
            for (int w = 0; w < 4; w++) begin
                in_w8[w*32 +: 32] = $urandom;
            end
            sel_w8 = 4'($urandom_range(0, 15));
            // First cycle is always valid so the held value is defined.
            valid_w1 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            valid_w8 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if (valid_w1) exp_w1 = ref_pick1(in_w1, int'(sel_w1));
            expv_w1 = valid_w1;
            if (valid_w8) exp_w8 = ref_pick8(in_w8, int'(sel_w8));
            expv_w8 = valid_w8;
            applyStimulus();
            checks++;
            if (out_w1 !== exp_w1 || out_valid_w1 !== expv_w1) begin
                errors++;
                $display("[TB] FAIL random_w1 n=%0d: out=%b valid=%b, want out=%b valid=%b",
                         n, out_w1, out_valid_w1, exp_w1, expv_w1);
            end
            checks++;
            if (out_w8 !== exp_w8 || out_valid_w8 !== expv_w8) begin
                errors++;
                $display("[TB] FAIL random_w8 n=%0d: out=%h valid=%b, want out=%h valid=%b",
                         n, out_w8, out_valid_w8, exp_w8, expv_w8);
            end
        end
    endtask

    // Scenario sequence, then the single summary line.
    initial begin
        in_w8 = '0;
        test_reset();
        test_sweep();
        test_walking_one();
        test_hold();
        test_async_reset();
        test_width8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
